gpr_wb_arbiter: RTL and testbench
=================================

// Module: gpr_wb_arbiter
// PURPOSE
//  Shares the single GPR write port (WE/WeSel/WData) between NREQ writeback sources.
//  Sources are ALU = req 0, LOAD = req 1 and MDU = req 2.
//  Each source uses a valid/ack handshake. Arbitration is round-robin, and the granted write is registered onto the port.
//  Also exports a pending-write mask so decode can stall on RAW hazards.
// PARAMETERS
//  NREQ  3   number of writeback requesters (2..8)
//  DW    32  data width
//  AW    5   register index width (2**AW registers; index 0 is hard-wired zero)
// PORTS
//  clk       in   1           rising-edge clock
//  rst       in   1           synchronous reset, active-high
//  ReqValid  in   NREQ        requester i has a write pending
//  ReqSel    in   NREQ*AW     dest reg of req i at [i*AW +: AW]
//  ReqData   in   NREQ*DW     write data of req i at [i*DW +: DW]
//  Hold      in   1           freeze: no new grants while high
//  ReqAck    out  NREQ        one-hot accept, combinational, same cycle
//  WE        out  1           GPR write enable (registered)
//  WeSel     out  AW          GPR write index (registered)
//  WData     out  DW          GPR write data (registered)
//  Pending   out  2**AW       bit r=1: reg r targeted by an un-acked valid req or by the current WE cycle
// BEHAVIOUR
//  Reset values: WE=0, WeSel=0, WData=0, ReqAck=0, rr pointer=NREQ-1 (req 0 wins first).
//  Handshake:
//   - A transfer occurs when ReqValid[i] & ReqAck[i].
//   - Requester holds Sel/Data stable until acked; deasserting before ack is allowed (request withdrawn).
//  Grant:
//   - ReqAck = 0 when rst | Hold | no valid requests.
//   - Otherwise exactly one bit is set: the first valid req searching ptr+1, ptr+2, ... mod NREQ.
//   - On a grant to i, ptr <= i.
//  Latency:
//   - Data acked in cycle N appears on WE/WeSel/WData in cycle N+1, for exactly one cycle.
//   - WE is 0 in any cycle following no transfer.
//   - Throughput is 1 write/cycle.
//  r0 writes: acked normally, but the output cycle carries WE=0, WeSel=0, WData=0.
//  Fairness: with Hold=0, a continuously valid requester is acked within NREQ cycles.
//  Same-dest collision: writes issue in grant order; the last-granted value is the one retained in the GPR.
//  Pending:
//   - Combinational OR over valid un-acked requests plus registered {WE,WeSel}.
//   - Bit 0 is always 0.
//   - A req acked this cycle still shows via the registered term next cycle.
//  Hold: ptr frozen; an already-registered write still issues on the next cycle.
//  Reset mid-operation: a registered write not yet issued is dropped (WE=0 next cycle); un-acked requests stay with their owners.
//  No state machine beyond the ptr and output registers; no internal buffering.
// CONFIGURATION
//  WB_FIXED_PRIO_EN
//   - Defined: fixed priority; lowest valid index always wins; ptr is unused and starvation is possible.
//   - Undefined (default): round-robin as above.
// TESTING
//  1 Reset: rst=1 for 2 cycles with all ReqValid=1 -> ReqAck=0, WE=0 throughout; first post-reset ack is 3'b001.
//  2 Single write: req1 Sel=5 Data=32'hDEADBEEF for 1 cycle -> ReqAck=3'b010; next cycle WE=1, WeSel=5, WData=DEADBEEF; Pending[5] high for both cycles.
//  3 Round-robin: ReqValid=3'b111 held, each req re-arming after ack -> acks 001,010,100,001; WE=1 on 4 consecutive cycles.
//    With WB_FIXED_PRIO_EN defined: acks 001,001,001,...
//  4 r0 write: req0 Sel=0 Data=32'h12345678 -> acked; next cycle WE=0; Pending[0]=0.
//  5 Hold: Hold=1 for 3 cycles with req2 valid (Sel=31) -> no ack and Pending[31]=1; Hold falls -> ack 3'b100 same cycle, WE next cycle.
//  6 Collision: req0 and req1 both Sel=7, data 32'h1 and 32'h2 -> two WE cycles to 7 in grant order; the last write holds 32'h2 (ptr at reset).

Source files
------------

// File: rtl/gpr_wb_arbiter_if.sv
// Writeback request bundle shared between the writeback sources and the GPR port arbiter.
//   ReqValid  source -> arbiter  per-source write pending
//   ReqSel    source -> arbiter  destination register of source i at [i*AW +: AW]
//   ReqData   source -> arbiter  write data of source i at [i*DW +: DW]
//   ReqAck    arbiter -> source  one-hot accept, valid in the same cycle
interface gpr_wb_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5
);
  logic [NREQ-1:0]    ReqValid;
  logic [NREQ*AW-1:0] ReqSel;
  logic [NREQ*DW-1:0] ReqData;
  logic [NREQ-1:0]    ReqAck;

  modport master (output ReqValid, ReqSel, ReqData, input ReqAck);
  modport slave  (input ReqValid, ReqSel, ReqData, output ReqAck);
endinterface

// File: rtl/gpr_wb_arbiter.sv
// Shares the single GPR write port between NREQ writeback sources (ALU=0, LOAD=1, MDU=2).
// The granted write is registered onto WE/WeSel/WData one cycle after its ack; Pending
// exposes every register with a write in flight so decode can stall on RAW hazards.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high
//   Hold     freezes arbitration (no new grants, pointer frozen)
//   req      request bundle (slave side): ReqValid/ReqSel/ReqData in, ReqAck out
//   WE       registered GPR write enable
//   WeSel    registered GPR write index
//   WData    registered GPR write data
//   Pending  per-register in-flight mask (combinational)
// Build option: define WB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer);
// the default build arbitrates round-robin.
module gpr_wb_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Hold,
  gpr_wb_arbiter_if.slave      req,
  output logic                 WE,
  output logic [AW-1:0]        WeSel,
  output logic [DW-1:0]        WData,
  output logic [(2**AW)-1:0]   Pending
);
  localparam int unsigned NREG = 2 ** AW;
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] ack;
  logic [PW-1:0]   gidx;
  logic [AW-1:0]   gsel;
  logic [DW-1:0]   gdata;

`ifdef WB_FIXED_PRIO_EN
  // Lowest valid index wins: scan downward so the smallest index is written last.
  always_comb begin
    ack  = '0;
    gidx = '0;
    if (!rst && !Hold) begin
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
        if (req.ReqValid[i]) begin
          ack  = NREQ'(1) << i;
          gidx = PW'(i);
        end
      end
    end
  end
`else
  logic [PW-1:0] ptr;
  int unsigned   idx;

  // Round-robin: candidates ptr+1 .. ptr+NREQ, scanned farthest first so the nearest wins.
  always_comb begin
    ack  = '0;
    gidx = '0;
    idx  = 0;
    if (!rst && !Hold) begin
      for (int unsigned k = NREQ; k >= 1; k--) begin
        idx = (32'(ptr) + k) % NREQ;
        if (req.ReqValid[PW'(idx)]) begin
          ack  = NREQ'(1) << idx;
          gidx = PW'(idx);
        end
      end
    end
  end

  // Pointer remembers the last grant; reset value makes req 0 win first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PW'(NREQ - 1);
    end else if (|ack) begin
      ptr <= gidx;
    end
  end
`endif

  assign req.ReqAck = ack;
  assign gsel       = req.ReqSel[32'(gidx) * AW +: AW];
  assign gdata      = req.ReqData[32'(gidx) * DW +: DW];

  // Write port register: r0 writes are accepted but issue as an all-zero idle cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      WE    <= 1'b0;
      WeSel <= '0;
      WData <= '0;
    end else if ((|ack) && (gsel != '0)) begin
      WE    <= 1'b1;
      WeSel <= gsel;
      WData <= gdata;
    end else begin
      WE    <= 1'b0;
      WeSel <= '0;
      WData <= '0;
    end
  end

  // Valid requests (including one being acked now) plus the write currently on the port.
  always_comb begin
    Pending = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req.ReqValid[i]) begin
        Pending[req.ReqSel[i * AW +: AW]] = 1'b1;
      end
    end
    if (WE) begin
      Pending[WeSel] = 1'b1;
    end
    Pending[0] = 1'b0;
  end

  // Keeps NREG meaningful for readers and guards against an illegal index width.
  if (NREG < 2) begin : g_bad_aw
    $error("AW must be at least 1");
  end
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed, table-driven bench for gpr_wb_arbiter (NREQ=3, DW=32, AW=5).
module tb_gpr_wb_arbiter;
  logic        clk;
  logic        rst;
  logic        Hold;
  logic        WE;
  logic [4:0]  WeSel;
  logic [31:0] WData;
  logic [31:0] Pending;

  gpr_wb_arbiter_if #(.NREQ(3), .DW(32), .AW(5)) bus ();

  gpr_wb_arbiter #(.NREQ(3), .DW(32), .AW(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .Hold    (Hold),
    .req     (bus),
    .WE      (WE),
    .WeSel   (WeSel),
    .WData   (WData),
    .Pending (Pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        hold;
    logic [2:0]  valid;
    logic [4:0]  s0, s1, s2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  ack;
    logic        we;
    logic        chk_sd;
    logic [4:0]  wsel;
    logic [31:0] wdata;
    logic [31:0] pend;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic h, input logic [2:0] v,
                     input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                     input logic [2:0] a, input logic we, input logic chk,
                     input logic [4:0] ws, input logic [31:0] wd, input logic [31:0] p);
    vec_t t;
    t.rst = r; t.hold = h; t.valid = v;
    t.s0 = s0; t.s1 = s1; t.s2 = s2;
    t.d0 = d0; t.d1 = d1; t.d2 = d2;
    t.ack = a; t.we = we; t.chk_sd = chk; t.wsel = ws; t.wdata = wd; t.pend = p;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic h, input logic [2:0] v,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    rst          = r;
    Hold         = h;
    bus.ReqValid = v;
    bus.ReqSel   = {s2, s1, s0};
    bus.ReqData  = {d2, d1, d0};
  endtask

  int cnt [3];

  initial begin
    // Reset with every request valid: no ack, no write.
    add(1,0,3'b111, 1,2,3, 32'hA0,32'hB1,32'hC2, 3'b000, 0,1, 0,0, 32'h0000_000E);
    add(1,0,3'b111, 1,2,3, 32'hA0,32'hB1,32'hC2, 3'b000, 0,1, 0,0, 32'h0000_000E);
    // Arbitration with all three sources continuously valid.
    add(0,0,3'b111, 1,2,3, 32'hA0,32'hB1,32'hC2, 3'b001, 0,0, 0,0, 32'h0000_000E);
`ifdef WB_FIXED_PRIO_EN
    add(0,0,3'b111, 1,2,3, 32'hA0,32'hB1,32'hC2, 3'b001, 1,1, 1,32'hA0, 32'h0000_000E);
    add(0,0,3'b111, 1,2,3, 32'hA0,32'hB1,32'hC2, 3'b001, 1,1, 1,32'hA0, 32'h0000_000E);
    add(0,0,3'b111, 1,2,3, 32'hA0,32'hB1,32'hC2, 3'b001, 1,1, 1,32'hA0, 32'h0000_000E);
`else
    add(0,0,3'b111, 1,2,3, 32'hA0,32'hB1,32'hC2, 3'b010, 1,1, 1,32'hA0, 32'h0000_000E);
    add(0,0,3'b111, 1,2,3, 32'hA0,32'hB1,32'hC2, 3'b100, 1,1, 2,32'hB1, 32'h0000_000E);
    add(0,0,3'b111, 1,2,3, 32'hA0,32'hB1,32'hC2, 3'b001, 1,1, 3,32'hC2, 32'h0000_000E);
`endif
    add(0,0,3'b000, 1,2,3, 32'hA0,32'hB1,32'hC2, 3'b000, 1,1, 1,32'hA0, 32'h0000_0002);
    add(0,0,3'b000, 0,0,0, 0,0,0,                3'b000, 0,0, 0,0,      32'h0);
    // Single write from LOAD.
    add(0,0,3'b010, 0,5,0, 0,32'hDEAD_BEEF,0,    3'b010, 0,0, 0,0,      32'h0000_0020);
    add(0,0,3'b000, 0,5,0, 0,32'hDEAD_BEEF,0,    3'b000, 1,1, 5,32'hDEAD_BEEF, 32'h0000_0020);
    add(0,0,3'b000, 0,0,0, 0,0,0,                3'b000, 0,0, 0,0,      32'h0);
    // r0 write: acked, issues as an idle cycle, never pending.
    add(0,0,3'b001, 0,0,0, 32'h1234_5678,0,0,    3'b001, 0,0, 0,0,      32'h0);
    add(0,0,3'b000, 0,0,0, 0,0,0,                3'b000, 0,1, 0,0,      32'h0);
    // Hold for three cycles, then the grant happens in the release cycle.
    add(0,1,3'b100, 0,0,31, 0,0,32'h5555_AAAA,   3'b000, 0,0, 0,0,      32'h8000_0000);
    add(0,1,3'b100, 0,0,31, 0,0,32'h5555_AAAA,   3'b000, 0,0, 0,0,      32'h8000_0000);
    add(0,1,3'b100, 0,0,31, 0,0,32'h5555_AAAA,   3'b000, 0,0, 0,0,      32'h8000_0000);
    add(0,0,3'b100, 0,0,31, 0,0,32'h5555_AAAA,   3'b100, 0,0, 0,0,      32'h8000_0000);
    add(0,0,3'b000, 0,0,0, 0,0,0,                3'b000, 1,1, 31,32'h5555_AAAA, 32'h8000_0000);
    add(0,0,3'b000, 0,0,0, 0,0,0,                3'b000, 0,0, 0,0,      32'h0);
    // Same-destination collision right after reset: req0 then req1, last value is 2.
    add(1,0,3'b000, 0,0,0, 0,0,0,                3'b000, 0,0, 0,0,      32'h0);
    add(0,0,3'b011, 7,7,0, 32'h1,32'h2,0,        3'b001, 0,1, 0,0,      32'h0000_0080);
    add(0,0,3'b010, 7,7,0, 32'h1,32'h2,0,        3'b010, 1,1, 7,32'h1,  32'h0000_0080);
    add(0,0,3'b000, 0,0,0, 0,0,0,                3'b000, 1,1, 7,32'h2,  32'h0000_0080);
    add(0,0,3'b000, 0,0,0, 0,0,0,                3'b000, 0,0, 0,0,      32'h0);
    // Reset mid-operation: the write on the port is cleared by the reset edge.
    add(0,0,3'b001, 9,0,0, 32'h99,0,0,           3'b001, 0,0, 0,0,      32'h0000_0200);
    add(1,0,3'b000, 0,0,0, 0,0,0,                3'b000, 1,1, 9,32'h99, 32'h0000_0200);
    add(0,0,3'b000, 0,0,0, 0,0,0,                3'b000, 0,1, 0,0,      32'h0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].hold, tbl[i].valid, tbl[i].s0, tbl[i].s1, tbl[i].s2,
            tbl[i].d0, tbl[i].d1, tbl[i].d2);
      @(negedge clk);
      check($sformatf("row%0d ack", i), 32'(bus.ReqAck), 32'(tbl[i].ack));
      check($sformatf("row%0d we", i), 32'(WE), 32'(tbl[i].we));
      if (tbl[i].chk_sd) begin
        check($sformatf("row%0d wesel", i), 32'(WeSel), 32'(tbl[i].wsel));
        check($sformatf("row%0d wdata", i), WData, tbl[i].wdata);
      end
      check($sformatf("row%0d pending", i), Pending, tbl[i].pend);
      @(posedge clk);
      #1;
    end

    // Fairness: three continuously valid sources over six cycles.
    cnt = '{0, 0, 0};
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, 3'b111, 1, 2, 3, 32'h10, 32'h20, 32'h30);
      @(negedge clk);
      check($sformatf("fair%0d onehot", c), 32'($onehot(bus.ReqAck)), 32'd1);
      for (int i = 0; i < 3; i++) cnt[i] += int'(bus.ReqAck[i]);
      @(posedge clk);
      #1;
    end
`ifdef WB_FIXED_PRIO_EN
    check("fair cnt0", 32'(cnt[0]), 32'd6);
`else
    check("fair cnt0", 32'(cnt[0]), 32'd2);
    check("fair cnt1", 32'(cnt[1]), 32'd2);
    check("fair cnt2", 32'(cnt[2]), 32'd2);
`endif
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Withdrawal under Hold: request vanishes before ack, nothing is written.
    drive(0, 1, 3'b100, 0, 0, 12, 0, 0, 32'h77);
    @(negedge clk);
    check("wd ack held", 32'(bus.ReqAck), 32'd0);
    check("wd pending", Pending, 32'h0000_1000);
    @(posedge clk);
    #1;
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("wd ack gone", 32'(bus.ReqAck), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wd we", 32'(WE), 32'd0);
    check("wd pending idle", Pending, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
